axis_sim_pkt_gen: RTL and testbench
===================================

// Module: axis_sim_pkt_gen
// PURPOSE
//  Synthesizable AXI4-Stream Ethernet frame generator that drives the 10G port ingress of the switch top.
//  It is instantiated in the simulation top in place of the SFP loopback, and on-board as a self-test source.
//  It emits configurable bursts of sequence-numbered frames with NetFPGA tuser metadata and reports progress.
// PARAMETERS
//  C_DATA_WIDTH    256    tdata width in bits; fixed 32-byte beat, other values unsupported
//  C_USER_WIDTH    128    tuser width in bits
//  SRC_PORT        8'h01  one-hot source port code placed in tuser[23:16]
//  ETHERTYPE       16'h88B5  ethertype written into frame bytes 12-13
// PORTS
//  axis_aclk          in   1    single clock; all logic on rising edge
//  axis_reset         in   1    asynchronous, active-high reset
//  cfg_start          in   1    one-cycle pulse; latches cfg_* and starts a burst (ignored while busy)
//  cfg_stop           in   1    pulse; finish current frame, then end burst
//  cfg_pkt_count      in   32   frames per burst; 0 = continuous until cfg_stop
//  cfg_pkt_len        in   16   frame length in bytes, clamped to [64,1518]
//  cfg_ifg            in   8    idle cycles inserted between frames (tvalid low)
//  cfg_dst_mac        in   48   destination MAC (bytes 0-5, MSB first)
//  cfg_src_mac        in   48   source MAC (bytes 6-11, MSB first)
//  m_axis_tdata       out  256  frame data; byte n of beat in tdata[8n+7:8n]
//  m_axis_tkeep       out  32   byte enables
//  m_axis_tuser       out  128  [15:0] len, [23:16] SRC_PORT, [31:24] 0, rest 0
//  m_axis_tvalid      out  1    beat valid
//  m_axis_tready      in   1    downstream ready
//  m_axis_tlast       out  1    last beat of frame
//  stat_busy          out  1    burst in progress
//  stat_done          out  1    one-cycle pulse when burst ends
//  stat_pkts_sent     out  32   frames completed since last cfg_start (wraps at 2^32)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0; asserting reset mid-frame drops tvalid immediately, no tlast.
//  FSM: IDLE -start-> HDR -accept-> PAY (if beats>1) | GAP/DONE ; PAY -last accept-> GAP or DONE;
//       GAP counts cfg_ifg cycles (0 = skip GAP, next HDR drives tvalid on the cycle after tlast accept) -> HDR;
//       DONE: pulse stat_done for 1 cycle, clear busy -> IDLE.
//  End-of-burst: after tlast accept, go DONE if stop_pending or (count!=0 and pkts_sent==count).
//  cfg_stop in IDLE: no effect. cfg_stop during GAP: go DONE at GAP end, no further frame.
//  Latency: tvalid rises the cycle after cfg_start; stat_busy rises the same cycle.
//  Handshake: beat transfers when tvalid&tready; tdata/tkeep/tuser/tlast held stable while tvalid&!tready;
//   tvalid never deasserted mid-frame; tuser constant for whole frame.
//  Length: L = clamp(cfg_pkt_len); beats = ceil(L/32); last tkeep = (L%32==0) ? 32'hFFFFFFFF : (1<<(L%32))-1;
//   non-last beats tkeep all ones; tlast only on beat beats-1.
//  Header beat: bytes 0-5 dst MAC, 6-11 src MAC, 12-13 ETHERTYPE (big-endian),
//   14-15 seq[15:0] (big-endian), bytes 16-31 = byte index.
//  Payload: frame byte i (i>=16) = i[7:0]; bytes beyond L on last beat driven 0.
//  seq: 16-bit, starts at 0 on cfg_start, increments per accepted tlast, wraps 0xFFFF->0.
//  stat_pkts_sent: increments on each accepted tlast; cleared on accepted cfg_start.
//  cfg_* sampled only on accepted cfg_start; changes during a burst have no effect.
//  cfg_start and cfg_stop in the same IDLE cycle: start a burst with stop_pending set (exactly one frame).
// TESTING
//  1 len=64,count=1,ifg=0,tready=1 -> 2 beats, tkeep FFFFFFFF then FFFFFFFF, tlast beat 2, tuser[15:0]=64, done pulse.
//  2 len=65,count=3,ifg=4 -> 3 beats/frame, last tkeep=00000001, seq 0,1,2, 4 idle cycles between frames, pkts_sent=3.
//  3 len=20 and len=2000 -> clamped to 64 (2 beats) and 1518 (48 beats, last tkeep=00003FFF).
//  4 random tready 50% -> tdata/tkeep/tlast stable under backpressure, byte i==i[7:0], no tvalid gaps mid-frame.
//  5 count=0, cfg_stop in frame 5 -> frame 5 completes with tlast, done pulse, pkts_sent=5; start while busy ignored.
//  6 axis_reset asserted mid-frame -> tvalid=0 same cycle; after release, new cfg_start gives seq=0, pkts_sent=0.

Source files
------------

// File: rtl/axis_sim_pkt_gen.sv
// AXI4-Stream Ethernet frame generator: bursts of sequence-numbered frames with
// NetFPGA tuser metadata, used as a simulation source and an on-board self-test.
module axis_sim_pkt_gen #(
  parameter int          C_DATA_WIDTH = 256,
  parameter int          C_USER_WIDTH = 128,
  parameter logic [7:0]  SRC_PORT     = 8'h01,
  parameter logic [15:0] ETHERTYPE    = 16'h88B5
) (
  input  logic                      axis_aclk,
  input  logic                      axis_reset,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic [31:0]               cfg_pkt_count,
  input  logic [15:0]               cfg_pkt_len,
  input  logic [7:0]                cfg_ifg,
  input  logic [47:0]               cfg_dst_mac,
  input  logic [47:0]               cfg_src_mac,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_USER_WIDTH-1:0]   m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      stat_busy,
  output logic                      stat_done,
  output logic [31:0]               stat_pkts_sent
);

  localparam int NB = C_DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic logic [10:0] clamp_len(input logic [15:0] len);
    if (len < 16'd64) begin
      return 11'd64;
    end else if (len > 16'd1518) begin
      return 11'd1518;
    end else begin
      return len[10:0];
    end
  endfunction

  // Header fields on beat 0, otherwise byte value = frame byte index; bytes past the length are zero.
  function automatic logic [C_DATA_WIDTH-1:0] build_data(
    input logic [5:0]  beat,
    input logic [10:0] len,
    input logic [47:0] dst,
    input logic [47:0] src,
    input logic [15:0] seq
  );
    logic [C_DATA_WIDTH-1:0] d;
    logic [10:0]             idx;
    logic [7:0]              b;
    d = '0;
    for (int n = 0; n < NB; n++) begin
      idx = {beat, 5'd0} + 11'(n);
      b   = (idx < len) ? idx[7:0] : 8'd0;
      if (beat == 6'd0) begin
        if (n < 6) begin
          b = dst[8*(5-n) +: 8];
        end else if (n < 12) begin
          b = src[8*(11-n) +: 8];
        end else if (n == 12) begin
          b = ETHERTYPE[15:8];
        end else if (n == 13) begin
          b = ETHERTYPE[7:0];
        end else if (n == 14) begin
          b = seq[15:8];
        end else if (n == 15) begin
          b = seq[7:0];
        end
      end
      d[8*n +: 8] = b;
    end
    return d;
  endfunction

  function automatic logic [NB-1:0] build_keep(input logic is_last, input logic [10:0] len);
    if (is_last && (len[4:0] != 5'd0)) begin
      return ({{(NB-1){1'b0}}, 1'b1} << len[4:0]) - {{(NB-1){1'b0}}, 1'b1};
    end else begin
      return '1;
    end
  endfunction

  logic [2:0]  state_r;
  logic [5:0]  beat_r;
  logic [10:0] len_r;
  logic [47:0] dst_r;
  logic [47:0] src_r;
  logic [31:0] count_r;
  logic [7:0]  ifg_r;
  logic [7:0]  gap_cnt_r;
  logic [15:0] seq_r;
  logic        stop_pending_r;

  logic                    accept_s;
  logic                    last_acc_s;
  logic                    end_burst_s;
  logic [10:0]             sel_len_s;
  logic [47:0]             sel_dst_s;
  logic [47:0]             sel_src_s;
  logic [15:0]             sel_seq_s;
  logic [5:0]              sel_beat_s;
  logic [5:0]              last_beat_s;
  logic                    tlast_s;
  logic [C_DATA_WIDTH-1:0] data_s;
  logic [NB-1:0]           keep_s;
  logic [C_USER_WIDTH-1:0] user_s;

  // Contents of the next beat to present; in IDLE the live cfg inputs feed the first header.
  always_comb begin
    accept_s    = m_axis_tvalid & m_axis_tready;
    last_acc_s  = accept_s & m_axis_tlast;
    end_burst_s = last_acc_s & (stop_pending_r | cfg_stop |
                  ((count_r != 32'd0) && ((stat_pkts_sent + 32'd1) == count_r)));
    if (state_r == S_IDLE) begin
      sel_len_s = clamp_len(cfg_pkt_len);
      sel_dst_s = cfg_dst_mac;
      sel_src_s = cfg_src_mac;
    end else begin
      sel_len_s = len_r;
      sel_dst_s = dst_r;
      sel_src_s = src_r;
    end
    if (last_acc_s) begin
      sel_seq_s = seq_r + 16'd1;
    end else if (state_r == S_IDLE) begin
      sel_seq_s = 16'd0;
    end else begin
      sel_seq_s = seq_r;
    end
    if (accept_s && !m_axis_tlast) begin
      sel_beat_s = beat_r + 6'd1;
    end else begin
      sel_beat_s = 6'd0;
    end
    last_beat_s = 6'((sel_len_s - 11'd1) >> 5);
    tlast_s     = (sel_beat_s == last_beat_s);
    data_s      = build_data(sel_beat_s, sel_len_s, sel_dst_s, sel_src_s, sel_seq_s);
    keep_s      = build_keep(tlast_s, sel_len_s);
    user_s      = {{(C_USER_WIDTH-32){1'b0}}, 8'h00, SRC_PORT, 5'd0, sel_len_s};
  end

  // Burst FSM and registered stream/status outputs.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_r        <= S_IDLE;
      beat_r         <= 6'd0;
      len_r          <= 11'd0;
      dst_r          <= 48'd0;
      src_r          <= 48'd0;
      count_r        <= 32'd0;
      ifg_r          <= 8'd0;
      gap_cnt_r      <= 8'd0;
      seq_r          <= 16'd0;
      stop_pending_r <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tuser   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      stat_busy      <= 1'b0;
      stat_done      <= 1'b0;
      stat_pkts_sent <= 32'd0;
    end else begin
      stat_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cfg_start) begin
            len_r          <= sel_len_s;
            dst_r          <= cfg_dst_mac;
            src_r          <= cfg_src_mac;
            count_r        <= cfg_pkt_count;
            ifg_r          <= cfg_ifg;
            seq_r          <= 16'd0;
            stat_pkts_sent <= 32'd0;
            stop_pending_r <= cfg_stop;
            stat_busy      <= 1'b1;
            beat_r         <= sel_beat_s;
            m_axis_tdata   <= data_s;
            m_axis_tkeep   <= keep_s;
            m_axis_tuser   <= user_s;
            m_axis_tlast   <= tlast_s;
            m_axis_tvalid  <= 1'b1;
            state_r        <= S_HDR;
          end
        end
        S_HDR, S_PAY: begin
          if (cfg_stop) begin
            stop_pending_r <= 1'b1;
          end
          if (accept_s) begin
            if (!m_axis_tlast || (!end_burst_s && (ifg_r == 8'd0))) begin
              beat_r       <= sel_beat_s;
              m_axis_tdata <= data_s;
              m_axis_tkeep <= keep_s;
              m_axis_tuser <= user_s;
              m_axis_tlast <= tlast_s;
              state_r      <= m_axis_tlast ? S_HDR : S_PAY;
            end else begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              gap_cnt_r     <= ifg_r;
              state_r       <= end_burst_s ? S_DONE : S_GAP;
            end
            if (m_axis_tlast) begin
              seq_r          <= seq_r + 16'd1;
              stat_pkts_sent <= stat_pkts_sent + 32'd1;
            end
          end
        end
        S_GAP: begin
          if (cfg_stop) begin
            stop_pending_r <= 1'b1;
          end
          if (gap_cnt_r <= 8'd1) begin
            if (stop_pending_r || cfg_stop) begin
              state_r <= S_DONE;
            end else begin
              beat_r        <= sel_beat_s;
              m_axis_tdata  <= data_s;
              m_axis_tkeep  <= keep_s;
              m_axis_tuser  <= user_s;
              m_axis_tlast  <= tlast_s;
              m_axis_tvalid <= 1'b1;
              state_r       <= S_HDR;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
          end
        end
        S_DONE: begin
          stat_done      <= 1'b1;
          stat_busy      <= 1'b0;
          stop_pending_r <= 1'b0;
          state_r        <= S_IDLE;
        end
        default: begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          stat_busy     <= 1'b0;
          state_r       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_sim_pkt_gen.sv
// Directed bench for axis_sim_pkt_gen: a table of burst configurations with
// hand-computed frame geometry, plus reset-state and mid-frame reset sequences.
module tb_axis_sim_pkt_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_start = 1'b0;
  logic         cfg_stop = 1'b0;
  logic [31:0]  cfg_pkt_count = 32'd0;
  logic [15:0]  cfg_pkt_len = 16'd0;
  logic [7:0]   cfg_ifg = 8'd0;
  logic [47:0]  cfg_dst_mac = 48'd0;
  logic [47:0]  cfg_src_mac = 48'd0;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic [127:0] tuser;
  logic         tvalid;
  logic         tready = 1'b0;
  logic         tlast;
  logic         busy;
  logic         done;
  logic [31:0]  pkts;

  always #5 clk = ~clk;

  axis_sim_pkt_gen dut (
    .axis_aclk      (clk),
    .axis_reset     (rst),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_pkt_count  (cfg_pkt_count),
    .cfg_pkt_len    (cfg_pkt_len),
    .cfg_ifg        (cfg_ifg),
    .cfg_dst_mac    (cfg_dst_mac),
    .cfg_src_mac    (cfg_src_mac),
    .m_axis_tdata   (tdata),
    .m_axis_tkeep   (tkeep),
    .m_axis_tuser   (tuser),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tlast   (tlast),
    .stat_busy      (busy),
    .stat_done      (done),
    .stat_pkts_sent (pkts)
  );

  typedef struct {
    int          len;
    int          count;
    int          ifg;
    int          rnd;
    int          elen;
    int          ebeats;
    logic [31:0] ekeep;
    int          nframes;
    int          stop_frame;
    int          busy_start;
  } vec_t;

  vec_t vt [0:6];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_data(input int b, input int len, input int seq,
                                            input logic [47:0] d, input logic [47:0] s);
    logic [127:0] hv;
    logic [255:0] r;
    int           i;
    hv = {d, s, 16'h88B5, 16'(seq)};
    r  = '0;
    for (int n = 0; n < 32; n++) begin
      i = b * 32 + n;
      if (i < len) begin
        if (i < 16) r[8*n +: 8] = hv[127-8*i -: 8];
        else        r[8*n +: 8] = 8'(i);
      end
    end
    return r;
  endfunction

  task automatic run_burst(input vec_t v, input logic [47:0] dmac, input logic [47:0] smac);
    int           frame, beat, idle, cyc, seen;
    bit           held;
    logic [255:0] hd;
    logic [31:0]  hk;
    logic [127:0] hu;
    logic         hl;
    logic [31:0]  ekeep;
    logic [127:0] euser;
    euser = {96'd0, 8'h00, 8'h01, 16'(v.elen)};
    hd = '0; hk = '0; hu = '0; hl = 1'b0;
    @(negedge clk);
    cfg_pkt_len   = 16'(v.len);
    cfg_pkt_count = 32'(v.count);
    cfg_ifg       = 8'(v.ifg);
    cfg_dst_mac   = dmac;
    cfg_src_mac   = smac;
    cfg_stop      = (v.stop_frame < 0);
    cfg_start     = 1'b1;
    tready        = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    chk("start_valid", tvalid, 1);
    chk("start_busy", busy, 1);
    chk("start_pkts", pkts, 0);
    frame = 0; beat = 0; idle = 0; cyc = 0; held = 0;
    while (frame < v.nframes && cyc < 4000) begin
      if (held) begin
        chk("hold_data", tdata, hd);
        chk("hold_ctl", {tvalid, tlast, tkeep, tuser}, {1'b1, hl, hk, hu});
      end
      if (beat != 0) begin
        chk("no_gap", tvalid, 1);
      end else if (tvalid) begin
        if (frame > 0) chk("ifg", idle, v.ifg);
        idle = 0;
      end else begin
        idle++;
      end
      tready   = (v.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_stop = (frame == v.stop_frame) && (beat == 1);
      if (v.busy_start != 0 && frame == 1 && beat == 1) begin
        cfg_start     = 1'b1;
        cfg_pkt_len   = 16'd200;
        cfg_pkt_count = 32'd1;
      end else begin
        cfg_start = 1'b0;
      end
      if (tvalid && tready) begin
        ekeep = (beat == v.ebeats - 1) ? v.ekeep : 32'hFFFFFFFF;
        chk("data", tdata, exp_data(beat, v.elen, frame, dmac, smac));
        chk("keep", tkeep, ekeep);
        chk("last", tlast, (beat == v.ebeats - 1));
        chk("user", tuser, euser);
        held = 0;
        beat++;
        if (beat == v.ebeats) begin
          beat = 0;
          frame++;
        end
      end else begin
        held = tvalid;
        hd = tdata; hk = tkeep; hl = tlast; hu = tuser;
      end
      cyc++;
      @(negedge clk);
    end
    cfg_stop  = 1'b0;
    cfg_start = 1'b0;
    tready    = 1'b1;
    chk("frames", frame, v.nframes);
    seen = 0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      if (done) begin
        seen = 1;
      end else begin
        chk("idle_tail", tvalid, 0);
        @(negedge clk);
      end
    end
    chk("done_seen", seen, 1);
    chk("done_busy", busy, 0);
    chk("done_pkts", pkts, v.nframes);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("post_idle", tvalid, 0);
  endtask

  initial begin
    //        len   cnt ifg rnd elen  beats keep          frames stop bstart
    vt[0] = '{64,   1,  0,  0,  64,   2,  32'hFFFFFFFF, 1,     99,  0};
    vt[1] = '{65,   3,  4,  0,  65,   3,  32'h00000001, 3,     99,  0};
    vt[2] = '{20,   1,  0,  0,  64,   2,  32'hFFFFFFFF, 1,     99,  0};
    vt[3] = '{2000, 1,  0,  0,  1518, 48, 32'h00003FFF, 1,     99,  0};
    vt[4] = '{100,  4,  2,  1,  100,  4,  32'h0000000F, 4,     99,  0};
    vt[5] = '{65,   0,  1,  0,  65,   3,  32'h00000001, 5,     4,   1};
    vt[6] = '{96,   0,  0,  0,  96,   3,  32'hFFFFFFFF, 1,     -1,  0};

    repeat (2) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pkts", pkts, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", {tkeep, tuser}, 0);
    rst = 1'b0;
    @(negedge clk);

    // A stop pulse in IDLE must not start anything.
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    @(negedge clk);
    chk("idle_stop_valid", tvalid, 0);
    chk("idle_stop_busy", busy, 0);

    for (int k = 0; k < 7; k++) begin
      run_burst(vt[k], 48'h0A1B2C3D4E50 + 48'(k), 48'h102030405060 ^ 48'(k << 8));
    end

    // Reset in the middle of the second frame of a continuous burst.
    @(negedge clk);
    cfg_pkt_len   = 16'd200;
    cfg_pkt_count = 32'd0;
    cfg_ifg       = 8'd0;
    cfg_start     = 1'b1;
    tready        = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_valid", tvalid, 1);
    chk("pre_rst_pkts", pkts, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", tvalid, 0);
    chk("mid_rst_last", tlast, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pkts", pkts, 0);
    chk("post_rst_valid", tvalid, 0);
    run_burst('{64, 2, 0, 0, 64, 2, 32'hFFFFFFFF, 2, 99, 0}, 48'hFFEEDDCCBBAA, 48'h112233445566);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
